// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding, default widths.
package dmem_arb_pkg;

  localparam int unsigned DMEM_ADDR_W = 16;
  localparam int unsigned DMEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: chooses the owner of the next memory access.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic req_cpu,
  input  logic req_ldr,
  input  logic last,
  input  logic lock,
  output logic grant_vld_c,
  output logic grant_own_c
);

  // Contention goes to whoever was not served last, unless a locked loader already owns the slot.
  always_comb begin
    grant_vld_c = req_cpu | req_ldr;
    grant_own_c = 1'(OWN_CPU);
    if (req_cpu && req_ldr) begin
      if (lock && (last == 1'(OWN_LDR))) begin
        grant_own_c = 1'(OWN_LDR);
      end else if (last == 1'(OWN_CPU)) begin
        grant_own_c = 1'(OWN_LDR);
      end else begin
        grant_own_c = 1'(OWN_CPU);
      end
    end else if (req_ldr) begin
      grant_own_c = 1'(OWN_LDR);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the CPU load/store path and the loader; one access per
// IDLE->ACC->RSP pass, round-robin on contention, stall back to the datapath while pending.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  input  logic              ldr_lock,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic              grant_vld_c;
  logic              grant_own_c;

  rr_pick2 u_pick (
    .req_cpu     (cpu_req),
    .req_ldr     (ldr_req),
    .last        (last_q),
    .lock        (ldr_lock),
    .grant_vld_c (grant_vld_c),
    .grant_own_c (grant_own_c)
  );

  // Last starts as LDR so the CPU wins the first contention after reset.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_LDR;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // Next state; the granted command is captured so ACC/RSP never look at live requests.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_vld_c) begin
          owner_d = owner_e'(grant_own_c);
          state_d = ACC;
          if (owner_e'(grant_own_c) == OWN_LDR) begin
            we_d    = ldr_we;
            addr_d  = ldr_addr;
            wdata_d = ldr_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      ACC: begin
        state_d = RSP;
      end
      RSP: begin
        last_d  = owner_q;
        state_d = IDLE;
        if (!we_q) begin
          if (owner_q == OWN_LDR) begin
            ldr_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory strobes and acks decode registered state only; read data bypasses in RSP.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    ldr_ack   = 1'b0;
    cpu_rdata = cpu_rdata_q;
    ldr_rdata = ldr_rdata_q;
    if (state_q == ACC) begin
      mem_write = we_q;
      mem_read  = ~we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
    if (state_q == RSP) begin
      if (owner_q == OWN_LDR) begin
        ldr_ack = 1'b1;
        if (!we_q) begin
          ldr_rdata = mem_rdata;
        end
      end else begin
        cpu_ack = 1'b1;
        if (!we_q) begin
          cpu_rdata = mem_rdata;
        end
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized contention
// checked against a transaction-level round-robin model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        clear;
  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ldr_req, ldr_we, ldr_ack, ldr_lock;
  logic [15:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter dut (
    .clk(clk), .clear(clear),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata), .ldr_lock(ldr_lock),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } op_t;
  typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; logic we; } ev_t;
  typedef struct { int cyc; logic [15:0] data; } exp_t;

  op_t  cpu_ops[$], ldr_ops[$];
  ev_t  cpu_evs[$], ldr_evs[$], mem_evs[$];
  int   stall_cyc[$];
  int   both_cnt = 0;
  exp_t exp_cpu[$], exp_ldr[$];

  int n_vec = 0;
  int n_err = 0;

  // Data memory: read data valid the cycle after mem_read; bd_* is a backdoor preload port.
  logic [15:0] mem_arr [0:65535];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr, bd_data;
  always @(posedge clk) begin
    if (bd_we) mem_arr[bd_addr] <= bd_data;
    if (mem_write) mem_arr[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= mem_arr[mem_addr];
  end

  // Reference model state
  logic [15:0] ref_mem [0:65535];
  logic        mdl_last;
  logic [15:0] mdl_rd_cpu, mdl_rd_ldr;

  always @(negedge clk) begin
    if (cpu_ack === 1'b1) cpu_evs.push_back('{cyc, 16'h0, cpu_rdata, 1'b0});
    if (ldr_ack === 1'b1) ldr_evs.push_back('{cyc, 16'h0, ldr_rdata, 1'b0});
    if (mem_read === 1'b1 || mem_write === 1'b1) mem_evs.push_back('{cyc, mem_addr, mem_wdata, mem_write});
    if (mem_read === 1'b1 && mem_write === 1'b1) both_cnt <= both_cnt + 1;
    if (cpu_stall === 1'b1) stall_cyc.push_back(cyc);
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b0;
    mdl_last = 1'b1; mdl_rd_cpu = 16'h0; mdl_rd_ldr = 16'h0;
  endtask

  // lock_mode: 0 never, 1 while loader has work, 2 always
  task automatic drive_ops(input int lock_mode);
    cpu_req = (cpu_ops.size() > 0);
    if (cpu_ops.size() > 0) begin
      cpu_we = cpu_ops[0].we; cpu_addr = cpu_ops[0].addr; cpu_wdata = cpu_ops[0].wdata;
    end
    ldr_req = (ldr_ops.size() > 0);
    if (ldr_ops.size() > 0) begin
      ldr_we = ldr_ops[0].we; ldr_addr = ldr_ops[0].addr; ldr_wdata = ldr_ops[0].wdata;
    end
    ldr_lock = (lock_mode == 2) || (lock_mode == 1 && ldr_ops.size() > 0);
  endtask

  // Each side keeps req high and presents its next op from the cycle after each ack.
  task automatic run_streams(input int lock_mode, output int t0, output logic timed_out);
    @(posedge clk); #1;
    drive_ops(lock_mode);
    t0 = cyc;
    for (int k = 0; k < 60 && (cpu_ops.size() > 0 || ldr_ops.size() > 0); k++) begin
      @(negedge clk);
      if (cpu_req && cpu_ack === 1'b1) void'(cpu_ops.pop_front());
      if (ldr_req && ldr_ack === 1'b1) void'(ldr_ops.pop_front());
      @(posedge clk); #1;
      drive_ops(lock_mode);
    end
    timed_out = (cpu_ops.size() > 0 || ldr_ops.size() > 0);
    cpu_ops.delete(); ldr_ops.delete();
    drive_ops(0);
  endtask

  // Transaction-level prediction: service order by round-robin rule, 3 cycles per access.
  task automatic predict(input int lock_mode);
    op_t cq[$]; op_t lq[$]; op_t op; logic pick_ldr; logic lock; exp_t e;
    cq = cpu_ops; lq = ldr_ops;
    exp_cpu.delete(); exp_ldr.delete();
    for (int k = 0; cq.size() > 0 || lq.size() > 0; k++) begin
      lock = (lock_mode != 0);
      if (cq.size() > 0 && lq.size() > 0) pick_ldr = (lock && mdl_last) ? 1'b1 : ~mdl_last;
      else pick_ldr = (lq.size() > 0);
      op = pick_ldr ? lq.pop_front() : cq.pop_front();
      if (op.we) ref_mem[op.addr] = op.wdata;
      else if (pick_ldr) mdl_rd_ldr = ref_mem[op.addr];
      else mdl_rd_cpu = ref_mem[op.addr];
      e.cyc = 2 + 3 * k;
      e.data = pick_ldr ? mdl_rd_ldr : mdl_rd_cpu;
      if (pick_ldr) exp_ldr.push_back(e); else exp_cpu.push_back(e);
      mdl_last = pick_ldr;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    clear = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
    cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    ldr_we = 1'b0; ldr_addr = 16'h0; ldr_wdata = 16'h0;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (cpu_ack !== 1'b0 || ldr_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b/%b want 0/0", cpu_ack, ldr_ack); end
    n_vec++; if (cpu_rdata !== 16'h0 || ldr_rdata !== 16'h0) begin n_err++; $display("FAIL reset_rdata got %h/%h want 0/0", cpu_rdata, ldr_rdata); end
    n_vec++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      n_err++; $display("FAIL reset_mem got r%b w%b a%h d%h want all 0", mem_read, mem_write, mem_addr, mem_wdata); end
    n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall_idle got %b want 0", cpu_stall); end
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 16'h0005;
    @(negedge clk);
    n_vec++; if (cpu_stall !== 1'b1 || cpu_ack !== 1'b0 || mem_read !== 1'b0) begin
      n_err++; $display("FAIL reset_stall_req got stall%b ack%b rd%b want 1 0 0", cpu_stall, cpu_ack, mem_read); end
    @(posedge clk); #1;
    cpu_req = 1'b0; clear = 1'b0;
    mdl_last = 1'b1; mdl_rd_cpu = 16'h0; mdl_rd_ldr = 16'h0;
  endtask

  task automatic test_cpu_read();
    int t0; logic to; int c0; int m0; int s0;
    preload(16'h0005, 16'h1234);
    c0 = cpu_evs.size(); m0 = mem_evs.size(); s0 = stall_cyc.size();
    cpu_ops.push_back('{1'b0, 16'h0005, 16'h0});
    run_streams(0, t0, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL cpu_read_timeout got timeout want ack"); end
    n_vec++; if (cpu_evs.size() - c0 !== 1) begin n_err++; $display("FAIL cpu_read_ackcount got %0d want 1", cpu_evs.size() - c0); end
    if (cpu_evs.size() > c0) begin
      n_vec++; if (cpu_evs[c0].cyc - t0 !== 2 || cpu_evs[c0].data !== 16'h1234) begin
        n_err++; $display("FAIL cpu_read_ack got t+%0d %h want t+2 1234", cpu_evs[c0].cyc - t0, cpu_evs[c0].data); end
    end
    n_vec++; if (mem_evs.size() - m0 !== 1) begin n_err++; $display("FAIL cpu_read_strobes got %0d want 1", mem_evs.size() - m0); end
    if (mem_evs.size() > m0) begin
      n_vec++; if (mem_evs[m0].cyc - t0 !== 1 || mem_evs[m0].addr !== 16'h0005 || mem_evs[m0].we !== 1'b0) begin
        n_err++; $display("FAIL cpu_read_mem got t+%0d a%h we%b want t+1 0005 0", mem_evs[m0].cyc - t0, mem_evs[m0].addr, mem_evs[m0].we); end
    end
    n_vec++; if (stall_cyc.size() - s0 !== 2) begin n_err++; $display("FAIL cpu_read_stall_len got %0d want 2", stall_cyc.size() - s0); end
    if (stall_cyc.size() - s0 >= 2) begin
      n_vec++; if (stall_cyc[s0] - t0 !== 0 || stall_cyc[s0+1] - t0 !== 1) begin
        n_err++; $display("FAIL cpu_read_stall got t+%0d,t+%0d want t+0,t+1", stall_cyc[s0] - t0, stall_cyc[s0+1] - t0); end
    end
    @(negedge clk);
    n_vec++; if (cpu_rdata !== 16'h1234) begin n_err++; $display("FAIL cpu_read_hold got %h want 1234", cpu_rdata); end
    mdl_last = 1'b0; mdl_rd_cpu = 16'h1234;
  endtask

  task automatic test_ldr_write_cpu_read();
    int t0; logic to; int c0; int l0; int m0;
    l0 = ldr_evs.size(); m0 = mem_evs.size();
    ldr_ops.push_back('{1'b1, 16'h0003, 16'hBEEF});
    run_streams(0, t0, to);
    ref_mem[16'h0003] = 16'hBEEF;
    n_vec++; if (to !== 1'b0 || ldr_evs.size() - l0 !== 1) begin n_err++; $display("FAIL ldr_write_ack got %0d acks want 1", ldr_evs.size() - l0); end
    if (mem_evs.size() > m0) begin
      n_vec++; if (mem_evs[m0].we !== 1'b1 || mem_evs[m0].addr !== 16'h0003 || mem_evs[m0].data !== 16'hBEEF) begin
        n_err++; $display("FAIL ldr_write_mem got we%b a%h d%h want 1 0003 beef", mem_evs[m0].we, mem_evs[m0].addr, mem_evs[m0].data); end
    end
    c0 = cpu_evs.size();
    cpu_ops.push_back('{1'b0, 16'h0003, 16'h0});
    run_streams(0, t0, to);
    n_vec++; if (to !== 1'b0 || cpu_evs.size() - c0 !== 1) begin n_err++; $display("FAIL cpu_readback_ack got %0d acks want 1", cpu_evs.size() - c0); end
    if (cpu_evs.size() > c0) begin
      n_vec++; if (cpu_evs[c0].data !== 16'hBEEF) begin n_err++; $display("FAIL cpu_readback got %h want beef", cpu_evs[c0].data); end
    end
    @(negedge clk);
    n_vec++; if (ldr_rdata !== 16'h0 || ldr_evs.size() - l0 !== 1) begin
      n_err++; $display("FAIL ldr_rdata_untouched got %h acks %0d want 0000 1", ldr_rdata, ldr_evs.size() - l0); end
  endtask

  task automatic test_contention();
    int t0; logic to; int c0; int l0;
    do_reset();
    for (int i = 0; i < 6; i++) preload(16'h0030 + 16'(i), 16'hC030 + 16'(i));
    c0 = cpu_evs.size(); l0 = ldr_evs.size();
    for (int i = 0; i < 3; i++) begin
      cpu_ops.push_back('{1'b0, 16'h0030 + 16'(i), 16'h0});
      ldr_ops.push_back('{1'b0, 16'h0033 + 16'(i), 16'h0});
    end
    run_streams(0, t0, to);
    n_vec++; if (to !== 1'b0 || cpu_evs.size() - c0 !== 3 || ldr_evs.size() - l0 !== 3) begin
      n_err++; $display("FAIL contention_counts got cpu %0d ldr %0d want 3 3", cpu_evs.size() - c0, ldr_evs.size() - l0); end
    for (int i = 0; i < 3 && c0 + i < cpu_evs.size(); i++) begin
      n_vec++; if (cpu_evs[c0+i].cyc - t0 !== 2 + 6 * i || cpu_evs[c0+i].data !== 16'hC030 + 16'(i)) begin
        n_err++; $display("FAIL contention_cpu%0d got t+%0d %h want t+%0d %h", i, cpu_evs[c0+i].cyc - t0, cpu_evs[c0+i].data, 2 + 6 * i, 16'hC030 + 16'(i)); end
    end
    for (int i = 0; i < 3 && l0 + i < ldr_evs.size(); i++) begin
      n_vec++; if (ldr_evs[l0+i].cyc - t0 !== 5 + 6 * i || ldr_evs[l0+i].data !== 16'hC033 + 16'(i)) begin
        n_err++; $display("FAIL contention_ldr%0d got t+%0d %h want t+%0d %h", i, ldr_evs[l0+i].cyc - t0, ldr_evs[l0+i].data, 5 + 6 * i, 16'hC033 + 16'(i)); end
    end
    mdl_last = 1'b1; mdl_rd_cpu = 16'hC032; mdl_rd_ldr = 16'hC035;
  endtask

  task automatic test_lock();
    int t0; logic to; int c0; int l0; int m0;
    logic [15:0] wv [4];
    c0 = cpu_evs.size(); l0 = ldr_evs.size(); m0 = mem_evs.size();
    for (int i = 0; i < 4; i++) begin
      wv[i] = 16'($urandom);
      ldr_ops.push_back('{1'b1, 16'h0010 + 16'(i), wv[i]});
    end
    cpu_ops.push_back('{1'b0, 16'h0012, 16'h0});
    run_streams(1, t0, to);
    n_vec++; if (to !== 1'b0 || ldr_evs.size() - l0 !== 4 || cpu_evs.size() - c0 !== 1) begin
      n_err++; $display("FAIL lock_counts got ldr %0d cpu %0d want 4 1", ldr_evs.size() - l0, cpu_evs.size() - c0); end
    for (int i = 0; i < 4 && l0 + i < ldr_evs.size(); i++) begin
      n_vec++; if (ldr_evs[l0+i].cyc - t0 !== 2 + 3 * i) begin
        n_err++; $display("FAIL lock_ldr%0d got t+%0d want t+%0d", i, ldr_evs[l0+i].cyc - t0, 2 + 3 * i); end
    end
    for (int i = 0; i < 4 && m0 + i < mem_evs.size(); i++) begin
      n_vec++; if (mem_evs[m0+i].we !== 1'b1 || mem_evs[m0+i].addr !== 16'h0010 + 16'(i) || mem_evs[m0+i].data !== wv[i]) begin
        n_err++; $display("FAIL lock_wr%0d got we%b a%h d%h want 1 %h %h", i, mem_evs[m0+i].we, mem_evs[m0+i].addr, mem_evs[m0+i].data, 16'h0010 + 16'(i), wv[i]); end
    end
    if (cpu_evs.size() > c0) begin
      n_vec++; if (cpu_evs[c0].cyc - t0 !== 14 || cpu_evs[c0].data !== wv[2]) begin
        n_err++; $display("FAIL lock_cpu got t+%0d %h want t+14 %h", cpu_evs[c0].cyc - t0, cpu_evs[c0].data, wv[2]); end
    end
    for (int i = 0; i < 4; i++) ref_mem[16'h0010 + 16'(i)] = wv[i];
    // Lock alone, without a loader request, must not hold off the CPU.
    c0 = cpu_evs.size();
    cpu_ops.push_back('{1'b0, 16'h0005, 16'h0});
    run_streams(2, t0, to);
    n_vec++; if (to !== 1'b0 || cpu_evs.size() - c0 !== 1) begin n_err++; $display("FAIL lock_idle_ldr got %0d acks want 1", cpu_evs.size() - c0); end
    if (cpu_evs.size() > c0) begin
      n_vec++; if (cpu_evs[c0].cyc - t0 !== 2 || cpu_evs[c0].data !== 16'h1234) begin
        n_err++; $display("FAIL lock_idle_ldr_ack got t+%0d %h want t+2 1234", cpu_evs[c0].cyc - t0, cpu_evs[c0].data); end
    end
  endtask

  task automatic test_back_to_back();
    int t0; logic to; int c0; int m0; int s0;
    c0 = cpu_evs.size(); m0 = mem_evs.size(); s0 = stall_cyc.size();
    cpu_ops.push_back('{1'b0, 16'h0005, 16'h0});
    cpu_ops.push_back('{1'b0, 16'h0003, 16'h0});
    run_streams(0, t0, to);
    repeat (3) @(negedge clk);
    n_vec++; if (to !== 1'b0 || cpu_evs.size() - c0 !== 2) begin n_err++; $display("FAIL b2b_ackcount got %0d want 2", cpu_evs.size() - c0); end
    if (cpu_evs.size() - c0 >= 2) begin
      n_vec++; if (cpu_evs[c0].cyc - t0 !== 2 || cpu_evs[c0].data !== 16'h1234 || cpu_evs[c0+1].cyc - t0 !== 5 || cpu_evs[c0+1].data !== 16'hBEEF) begin
        n_err++; $display("FAIL b2b_acks got t+%0d %h, t+%0d %h want t+2 1234, t+5 beef",
          cpu_evs[c0].cyc - t0, cpu_evs[c0].data, cpu_evs[c0+1].cyc - t0, cpu_evs[c0+1].data); end
    end
    n_vec++; if (mem_evs.size() - m0 !== 2) begin n_err++; $display("FAIL b2b_strobes got %0d want 2", mem_evs.size() - m0); end
    if (mem_evs.size() - m0 >= 2) begin
      n_vec++; if (mem_evs[m0].addr !== 16'h0005 || mem_evs[m0+1].addr !== 16'h0003 || mem_evs[m0+1].cyc - t0 !== 4) begin
        n_err++; $display("FAIL b2b_addr got %h,%h at t+%0d want 0005,0003 at t+4", mem_evs[m0].addr, mem_evs[m0+1].addr, mem_evs[m0+1].cyc - t0); end
    end
    n_vec++; if (stall_cyc.size() - s0 !== 4) begin n_err++; $display("FAIL b2b_stall got %0d stall cycles want 4", stall_cyc.size() - s0); end
    mdl_rd_cpu = 16'hBEEF;
  endtask

  task automatic test_clear_abort();
    int t0; logic to; int c0; int m0;
    preload(16'h0040, 16'h5A5A);
    c0 = cpu_evs.size(); m0 = mem_evs.size();
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0040; cpu_req = 1'b1;
    @(posedge clk); #1;
    clear = 1'b1;
    @(negedge clk);
    n_vec++; if (mem_read !== 1'b1 || mem_addr !== 16'h0040) begin
      n_err++; $display("FAIL abort_acc got rd%b a%h want 1 0040", mem_read, mem_addr); end
    @(posedge clk); #1;
    clear = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    n_vec++; if (cpu_ack !== 1'b0 || cpu_rdata !== 16'h0 || ldr_rdata !== 16'h0 || mem_read !== 1'b0) begin
      n_err++; $display("FAIL abort_state got ack%b rdata %h/%h rd%b want 0 0000/0000 0", cpu_ack, cpu_rdata, ldr_rdata, mem_read); end
    repeat (3) @(negedge clk);
    n_vec++; if (cpu_evs.size() - c0 !== 0 || mem_evs.size() - m0 !== 1) begin
      n_err++; $display("FAIL abort_noack got %0d acks %0d strobes want 0 1", cpu_evs.size() - c0, mem_evs.size() - m0); end
    mdl_last = 1'b1; mdl_rd_cpu = 16'h0; mdl_rd_ldr = 16'h0;
    cpu_ops.push_back('{1'b0, 16'h0040, 16'h0});
    run_streams(0, t0, to);
    n_vec++; if (to !== 1'b0 || cpu_evs.size() - c0 !== 1) begin n_err++; $display("FAIL abort_retry got %0d acks want 1", cpu_evs.size() - c0); end
    if (cpu_evs.size() > c0) begin
      n_vec++; if (cpu_evs[c0].cyc - t0 !== 2 || cpu_evs[c0].data !== 16'h5A5A) begin
        n_err++; $display("FAIL abort_retry_ack got t+%0d %h want t+2 5a5a", cpu_evs[c0].cyc - t0, cpu_evs[c0].data); end
    end
  endtask

  task automatic test_random();
    int t0; logic to; int c0; int l0; int m0; int nc; int nl; int lm; int b0;
    op_t op;
    do_reset();
    for (int i = 0; i < 8; i++) preload(16'h0020 + 16'(i), 16'($urandom));
    b0 = both_cnt;
    for (int r = 0; r < 30; r++) begin
      nc = $urandom_range(0, 2); nl = $urandom_range(0, 2);
      if (nc == 0 && nl == 0) nc = 1;
      lm = ($urandom_range(0, 3) == 0) ? 1 : 0;
      for (int i = 0; i < nc; i++) begin
        op.we = 1'($urandom); op.addr = 16'h0020 + 16'($urandom_range(0, 7)); op.wdata = 16'($urandom);
        cpu_ops.push_back(op);
      end
      for (int i = 0; i < nl; i++) begin
        op.we = 1'($urandom); op.addr = 16'h0020 + 16'($urandom_range(0, 7)); op.wdata = 16'($urandom);
        ldr_ops.push_back(op);
      end
      predict(lm);
      c0 = cpu_evs.size(); l0 = ldr_evs.size(); m0 = mem_evs.size();
      run_streams(lm, t0, to);
      n_vec++; if (to !== 1'b0 || cpu_evs.size() - c0 !== exp_cpu.size() || ldr_evs.size() - l0 !== exp_ldr.size()) begin
        n_err++; $display("FAIL rnd%0d_counts got cpu %0d ldr %0d want %0d %0d", r, cpu_evs.size() - c0, ldr_evs.size() - l0, exp_cpu.size(), exp_ldr.size()); end
      for (int i = 0; i < exp_cpu.size() && c0 + i < cpu_evs.size(); i++) begin
        n_vec++; if (cpu_evs[c0+i].cyc - t0 !== exp_cpu[i].cyc || cpu_evs[c0+i].data !== exp_cpu[i].data) begin
          n_err++; $display("FAIL rnd%0d_cpu%0d got t+%0d %h want t+%0d %h", r, i, cpu_evs[c0+i].cyc - t0, cpu_evs[c0+i].data, exp_cpu[i].cyc, exp_cpu[i].data); end
      end
      for (int i = 0; i < exp_ldr.size() && l0 + i < ldr_evs.size(); i++) begin
        n_vec++; if (ldr_evs[l0+i].cyc - t0 !== exp_ldr[i].cyc || ldr_evs[l0+i].data !== exp_ldr[i].data) begin
          n_err++; $display("FAIL rnd%0d_ldr%0d got t+%0d %h want t+%0d %h", r, i, ldr_evs[l0+i].cyc - t0, ldr_evs[l0+i].data, exp_ldr[i].cyc, exp_ldr[i].data); end
      end
      n_vec++; if (mem_evs.size() - m0 !== nc + nl) begin
        n_err++; $display("FAIL rnd%0d_strobes got %0d want %0d", r, mem_evs.size() - m0, nc + nl); end
    end
    n_vec++; if (both_cnt - b0 !== 0) begin n_err++; $display("FAIL strobe_exclusive got %0d overlap cycles want 0", both_cnt - b0); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_ldr_write_cpu_read();
    test_contention();
    test_lock();
    test_back_to_back();
    test_clear_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish after %0d vectors", n_vec);
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single 16-bit data memory between the CPU datapath (load/store path) and the program/data loader used to preload memory and inspect results. It serialises accesses and applies round-robin priority on contention, with an optional loader lock for multi-word transfers. It also drives a stall back to the PC/datapath while a CPU access is pending. It sits between the datapath's memory-stage signals and the Data_Memory instance.

## Interface
- ADDR_W, 16, address width of the data memory
- DATA_W, 16, data word width
- clk  in  1  system clock; all state changes on rising edge
- clear  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  CPU read data
- cpu_stall  out  1  cpu_req & ~cpu_ack; freezes PC and register write
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata  same as CPU set, loader side
- ldr_lock  in  1  loader holds priority while high
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_read

## Operation
- States: IDLE, ACC, RSP; owner register (CPU/LDR); last register (last served owner).
- IDLE: if neither req, stay. One req: owner <= that requester, go ACC. Both: owner <= ldr if ldr_lock & last==LDR, else the requester not equal to last; go ACC.
- Requests are sampled only in IDLE; a req withdrawn before the grant is simply not served.
- ACC (1 cycle): mem_addr/mem_wdata = owner's fields; mem_write = owner_we, mem_read = ~owner_we. Go RSP.
- RSP (1 cycle): owner's ack = 1; on read, owner's rdata = mem_rdata (bypass) and the value is captured into the owner's rdata register; last <= owner; go IDLE.
- x_rdata holds the last captured read value; writes never alter it; the other requester's rdata is never affected.
- Requester may change fields and re-raise req from the cycle after ack; req high during the ack cycle is ignored (RSP does not sample).
- Req dropped during ACC/RSP: protocol violation; access still completes, ack still pulses.
- Outside ACC: mem_read = mem_write = 0, mem_addr/mem_wdata = 0.
- ldr_lock with ldr_req low does not block the CPU.

## Timing
- Reset (clear sampled high): state IDLE, owner CPU, last LDR (CPU wins first contention), all ack 0, all rdata 0, mem strobes 0, cpu_stall = cpu_req. Clear mid-ACC/RSP aborts: no ack issued; memory write already strobed stays written.
- Latency: req high in IDLE at cycle t -> ACC at t+1 -> ack and read data at t+2.
- Throughput: one access per 3 cycles; a contending requester waits at most one access (ack at t+5), unless ldr_lock is high.
- mem strobes are exactly one cycle per access; never both high.
- acks are decoded from registered state/owner; no combinational path from req to ack or mem outputs.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, ACC, RSP), owner encoding (OWN_CPU=0, OWN_LDR=1), ADDR_W/DATA_W defaults.
- One sub-module rr_pick2: 2-way round-robin picker (reqs, last, lock -> grant owner), combinational.
- Top: FSM, owner/last registers, two rdata registers, output muxing.

## Test plan
- Reset then CPU-only read of addr 0x0005 preloaded 0x1234 -> mem_read at t+1 with mem_addr 0x0005, cpu_ack and cpu_rdata 0x1234 at t+2, cpu_stall high t..t+1.
- Loader write 0xBEEF to 0x0003, then CPU read 0x0003 -> ldr_ack once, cpu_rdata 0xBEEF, ldr_rdata unchanged (0).
- Both req same cycle after reset -> CPU served first (ack t+2), loader ack t+5; repeated contention alternates CPU, LDR, CPU.
- ldr_lock high, loader writes 4 words at 0x0010-0x0013 with CPU requesting throughout -> four ldr_acks before any cpu_ack; CPU served first after lock drops.
- clear asserted in ACC of a CPU read -> no cpu_ack, state IDLE, cpu_rdata 0 next cycle; re-issued read completes normally.
- Req held high through ack cycle with new address -> new access starts from the following IDLE, no double ack for the old address.
